imem_loader: RTL

Boot-time writer for the instruction memory: receives a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them to consecutive word addresses of the instruction memory. The CPU core is held in reset while loading. Release happens only after a complete, valid image has been written. It sits between the host/UART byte source and the write port of `inst_memory`, opposite the PC-driven read port.

---
 rtl/imem_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Accepts a little-endian byte stream (4-byte word count, then the words),
// assembles 32-bit instructions and writes them to consecutive word addresses.
// The CPU core is held in reset until a complete, valid image has been written.
module imem_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cpu_rst_o
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       byte_cnt;
    logic [31:0]      len;
    logic [23:0]      shift;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [31:0]      len_full;
    logic [31:0]      word_full;
    logic             accept;
    logic             last_byte;
    logic             start_ok;

    // Acceptance is derived from state directly so that ready never depends on valid.
    assign accept    = byte_valid_i && ((state == S_LEN) || (state == S_DATA));
    assign last_byte = accept && (byte_cnt == 2'd3);
    assign start_ok  = start_i && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

    // New bytes enter at the top, so after four shifts the first byte sits in bits 7:0.
    assign len_full  = {byte_data_i, len[31:8]};
    assign word_full = {byte_data_i, shift};
    assign idx_inc   = idx + 1'b1;

    // All status outputs are pure decodes of the registered state.
    assign byte_ready_o = (state == S_LEN) || (state == S_DATA);
    assign wr_en_o      = (state == S_WRITE);
    assign busy_o       = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
    assign done_o       = (state == S_DONE);
    assign err_o        = (state == S_ERR);
    assign cpu_rst_o    = (state != S_DONE);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: length check on the 4th length byte, word count check after each write.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_LEN;
            end
            S_LEN: begin
                if (last_byte) begin
                    if (len_full == 32'd0)               state_next = S_DONE;
                    else if (len_full > 32'(MAX_WORDS))  state_next = S_ERR;
                    else                                 state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (last_byte) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (32'(idx_inc) == len) state_next = S_DONE;
                else                     state_next = S_DATA;
            end
            S_DONE, S_ERR: begin
                if (start_ok) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Byte counter, length, word assembly, write index and the held write address/data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_cnt  <= '0;
            idx       <= '0;
            len       <= '0;
            shift     <= '0;
            wr_addr_o <= BASE_ADDR;
            wr_data_o <= '0;
        end else if (start_ok) begin
            byte_cnt <= '0;
            idx      <= '0;
            len      <= '0;
        end else begin
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (accept && (state == S_LEN)) begin
                len <= len_full;
            end
            if (accept && (state == S_DATA)) begin
                shift <= word_full[31:8];
            end
            // Address and data are loaded as the word completes and then held until the next word.
            if (last_byte && (state == S_DATA)) begin
                wr_data_o <= word_full;
                wr_addr_o <= BASE_ADDR + (ADDR_W'(idx) << 2);
            end
            if (state == S_WRITE) begin
                idx <= idx_inc;
            end
        end
    end

endmodule
